// File: rtl/lzss_dec_top_if.sv
// Code-in / symbol-out handshake bundle for the LZSS decoder.
// master: code producer + symbol consumer; slave: the decoder.
interface lzss_dec_top_if #(
  parameter int pDataWidth = 8,
  parameter int pCodeWidth = 10
);
  logic                  i_valid;
  logic                  ow_ready;
  logic [pCodeWidth-1:0] i_code;
  logic                  i_last;
  logic                  o_valid;
  logic                  i_ready;
  logic [pDataWidth-1:0] o_data;
  logic                  o_last;

  modport master (
    output i_valid, i_code, i_last, i_ready,
    input  ow_ready, o_valid, o_data, o_last
  );

  modport slave (
    input  i_valid, i_code, i_last, i_ready,
    output ow_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/lzss_dec_top.sv
// LZSS decoder: literal / (offset,len) codes in, symbols out.
// Ports: clk, rst_x (async, active-high), bus (code in, data out).
module lzss_dec_top #(
  parameter int pDataWidth     = 8,
  parameter int pReferenceSize = 64,
  parameter int pCodingSize    = 5,
  parameter int pCodeWidth     = 1 + (
    (pDataWidth > $clog2(pReferenceSize) + $clog2(pCodingSize))
      ? pDataWidth
      : $clog2(pReferenceSize) + $clog2(pCodingSize))
) (
  input logic           clk,
  input logic           rst_x,
  lzss_dec_top_if.slave bus
);
  localparam int OW = $clog2(pReferenceSize);
  localparam int LW = $clog2(pCodingSize);

  typedef enum logic {IDLE, COPY} state_t;

  state_t                state, state_d;
  logic [pDataWidth-1:0] hist [pReferenceSize];
  logic [OW-1:0]         idx, idx_d;
  logic [LW-1:0]         rem, rem_d;
  logic                  pend, pend_d;
  logic                  free, ack, clear, accept;
  logic                  is_match, load, ld_last;
  logic [OW-1:0]         off, new_idx;
  logic [LW-1:0]         len_m1;
  logic [pDataWidth-1:0] sym;

  assign free     = ~bus.o_valid | bus.i_ready;
  assign ack      = bus.o_valid & bus.i_ready;
  // Ack of the final symbol wipes history for the next stream.
  assign clear    = ack & bus.o_last;
  assign bus.ow_ready = ~rst_x & (state == IDLE) & free;
  assign accept   = bus.i_valid & bus.ow_ready;
  assign is_match = bus.i_code[pCodeWidth-1];
  assign off      = bus.i_code[LW +: OW];
  assign len_m1   = bus.i_code[LW-1:0];
  // Distance D = R - offset, source slot D-1.
  assign new_idx  = OW'(pReferenceSize - 1) - off;

  always_ff @(posedge clk or posedge rst_x) begin
    if (rst_x) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    rem_d   = rem;
    pend_d  = pend;
    load    = 1'b0;
    ld_last = 1'b0;
    sym     = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (!is_match) begin
            sym     = bus.i_code[pDataWidth-1:0];
            ld_last = bus.i_last;
          end else begin
            // A code taken alongside the stream-end ack
            // sees the cleared history.
            sym = clear ? '0 : hist[new_idx];
            if (len_m1 == '0) begin
              ld_last = bus.i_last;
            end else begin
              idx_d   = new_idx;
              rem_d   = len_m1;
              pend_d  = bus.i_last;
              state_d = COPY;
            end
          end
        end
      end
      COPY: begin
        if (free) begin
          // Fixed index over a shifting history makes
          // overlapping copies replicate.
          load  = 1'b1;
          sym   = hist[idx];
          rem_d = rem - 1'b1;
          if (rem == LW'(1)) begin
            ld_last = pend;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_x) begin
    if (rst_x) begin
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_last  <= 1'b0;
      rem         <= '0;
      idx         <= '0;
      pend        <= 1'b0;
      for (int i = 0; i < pReferenceSize; i++) hist[i] <= '0;
    end else begin
      rem  <= rem_d;
      idx  <= idx_d;
      pend <= pend_d;
      if (load) begin
        bus.o_valid <= 1'b1;
        bus.o_data  <= sym;
        bus.o_last  <= ld_last;
      end else begin
        if (ack)   bus.o_valid <= 1'b0;
        if (clear) bus.o_last  <= 1'b0;
      end
      if (load) begin
        hist[0] <= sym;
        for (int i = 1; i < pReferenceSize; i++)
          hist[i] <= clear ? '0 : hist[i-1];
      end else if (clear) begin
        for (int i = 0; i < pReferenceSize; i++) hist[i] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_lzss_dec_top.sv
// Randomized + directed bench for lzss_dec_top.
// Reference model expands codes into symbols using a stream list.
module tb_lzss_dec_top;
  logic clk = 1'b0;
  logic rst_x;
  always #5 clk = ~clk;

  lzss_dec_top_if bus ();

  lzss_dec_top dut (
    .clk  (clk),
    .rst_x(rst_x),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] cq[$];
  bit         lq[$];
  logic [7:0] ed[$];
  bit         el[$];
  logic [7:0] od[$];
  bit         ol[$];
  int         oc[$];
  int         ac[$];
  bit         rq[$];
  int         stall_bad;
  bit         tmo;

  // Expand the code list into the expected symbol stream.
  task automatic model();
    logic [7:0] h[$];
    logic [9:0] c;
    int d, l;
    logic [7:0] s;
    ed.delete();
    el.delete();
    foreach (cq[i]) begin
      c = cq[i];
      if (!c[9]) begin
        h.push_back(c[7:0]);
        ed.push_back(c[7:0]);
        el.push_back(lq[i]);
      end else begin
        d = 64 - int'(c[8:3]);
        l = int'(c[2:0]) + 1;
        for (int k = 0; k < l; k++) begin
          s = (h.size() >= d) ? h[h.size() - d] : 8'h00;
          h.push_back(s);
          ed.push_back(s);
          el.push_back(lq[i] && (k == l - 1));
        end
      end
      if (lq[i]) h.delete();
    end
  endtask

  // Drive cq/lq, record everything observed; no judging here.
  task automatic drive(input int rmode, input int budget);
    int  ci = 0;
    int  k = 0;
    int  idle = 0;
    bit  prev_stall = 0;
    bit  tog = 1;
    logic [7:0] pd = 0;
    bit  pl = 0;
    od.delete(); ol.delete(); oc.delete(); ac.delete(); rq.delete();
    stall_bad = 0;
    tmo = 0;
    forever begin
      @(negedge clk);
      if (prev_stall && (bus.o_valid !== 1'b1 || bus.o_data !== pd ||
                         bus.o_last !== pl))
        stall_bad++;
      case (rmode)
        0: bus.i_ready = 1'b1;
        1: begin bus.i_ready = tog; tog = ~tog; end
        default: bus.i_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (ci < cq.size() && (rmode != 2 || $urandom_range(0, 3) != 0)) begin
        bus.i_valid = 1'b1;
        bus.i_code  = cq[ci];
        bus.i_last  = lq[ci];
      end else begin
        bus.i_valid = 1'b0;
        bus.i_code  = 10'($urandom);
        bus.i_last  = 1'($urandom);
      end
      #1;
      if (bus.i_ready) rq.push_back(bus.ow_ready);
      if (bus.i_valid && bus.ow_ready) begin
        ac.push_back(cyc);
        ci++;
      end
      if (bus.o_valid && bus.i_ready) begin
        od.push_back(bus.o_data);
        ol.push_back(bus.o_last);
        oc.push_back(cyc);
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      pd = bus.o_data;
      pl = bus.o_last;
      cyc++;
      k++;
      if (ci == cq.size() && od.size() >= ed.size()) idle++;
      if (idle == 5) break;
      if (k > budget) begin
        tmo = 1;
        break;
      end
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_x = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_code = '0;
    bus.i_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL rst_o_valid got %b exp 0", bus.o_valid);
    end
    checks++;
    if (bus.o_data !== 8'h00) begin
      errors++; $display("FAIL rst_o_data got %h exp 00", bus.o_data);
    end
    checks++;
    if (bus.o_last !== 1'b0) begin
      errors++; $display("FAIL rst_o_last got %b exp 0", bus.o_last);
    end
    checks++;
    if (bus.ow_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ow_ready got %b exp 0", bus.ow_ready);
    end
    @(negedge clk);
    rst_x = 1'b0;
    #1;
    checks++;
    if (bus.ow_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_ow_ready got %b exp 1", bus.ow_ready);
    end
  endtask

  task automatic test_literals();
    logic [7:0] exp_d[3] = '{8'h41, 8'h42, 8'h43};
    int zeros = 0;
    cq = '{10'h041, 10'h042, 10'h043};
    lq = '{0, 0, 1};
    model();
    drive(0, 200);
    checks++;
    if (tmo || od.size() != 3) begin
      errors++; $display("FAIL lit_count got %0d exp 3 (tmo %0d)", od.size(), tmo);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (od[i] !== exp_d[i]) begin
          errors++; $display("FAIL lit_data[%0d] got %h exp %h", i, od[i], exp_d[i]);
        end
      end
      checks++;
      if (oc[0] != ac[0] + 1) begin
        errors++; $display("FAIL lit_latency got %0d exp 1", oc[0] - ac[0]);
      end
      checks++;
      if (oc[2] - oc[0] != 2 || ac[2] - ac[0] != 2) begin
        errors++; $display("FAIL lit_b2b got out %0d acc %0d exp 2 2",
                           oc[2] - oc[0], ac[2] - ac[0]);
      end
    end
    foreach (rq[i]) if (!rq[i]) zeros++;
    checks++;
    if (zeros != 0) begin
      errors++; $display("FAIL lit_ow_ready_low got %0d exp 0", zeros);
    end
  endtask

  task automatic test_match_repeat();
    int zeros = 0;
    cq = '{10'h041, 10'h3FB};
    lq = '{0, 1};
    model();
    drive(0, 200);
    checks++;
    if (tmo || od.size() != 5) begin
      errors++; $display("FAIL rep_count got %0d exp 5 (tmo %0d)", od.size(), tmo);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (od[i] !== 8'h41 || ol[i] !== (i == 4)) begin
          errors++; $display("FAIL rep_sym[%0d] got %h/%b exp 41/%b",
                             i, od[i], ol[i], (i == 4));
        end
      end
    end
    foreach (rq[i]) if (!rq[i]) zeros++;
    checks++;
    if (zeros != 3) begin
      errors++; $display("FAIL rep_copy_stall got %0d exp 3", zeros);
    end
  endtask

  task automatic test_overlap(input int rmode);
    logic [7:0] exp_d[8] = '{8'h41, 8'h42, 8'h43, 8'h41,
                              8'h42, 8'h43, 8'h41, 8'h42};
    cq = '{10'h041, 10'h042, 10'h043, 10'h3EC};
    lq = '{0, 0, 0, 1};
    model();
    drive(rmode, 300);
    checks++;
    if (tmo || od.size() != 8) begin
      errors++; $display("FAIL ovl%0d_count got %0d exp 8 (tmo %0d)",
                         rmode, od.size(), tmo);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (od[i] !== exp_d[i] || ol[i] !== (i == 7)) begin
          errors++; $display("FAIL ovl%0d_sym[%0d] got %h/%b exp %h/%b",
                             rmode, i, od[i], ol[i], exp_d[i], (i == 7));
        end
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL ovl%0d_stall_hold got %0d exp 0", rmode, stall_bad);
    end
  endtask

  task automatic test_stream_restart();
    cq = '{10'h041, 10'h3F8};
    lq = '{1, 1};
    model();
    drive(0, 200);
    checks++;
    if (tmo || od.size() != 2) begin
      errors++; $display("FAIL rs_count got %0d exp 2 (tmo %0d)", od.size(), tmo);
    end else begin
      checks++;
      if (od[0] !== 8'h41 || ol[0] !== 1'b1) begin
        errors++; $display("FAIL rs_first got %h/%b exp 41/1", od[0], ol[0]);
      end
      checks++;
      if (od[1] !== 8'h00 || ol[1] !== 1'b1) begin
        errors++; $display("FAIL rs_cleared got %h/%b exp 00/1", od[1], ol[1]);
      end
    end
    checks++;
    if (bus.o_last !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL rs_last_clear got %b/%b exp 0/0",
                         bus.o_last, bus.o_valid);
    end
  endtask

  task automatic test_reset_mid_copy();
    @(negedge clk);
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_code  = 10'h041;
    bus.i_last  = 1'b0;
    @(negedge clk);
    bus.i_code  = 10'h3FC;
    bus.i_last  = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst_x = 1'b1;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.ow_ready !== 1'b0) begin
      errors++; $display("FAIL rmc_abort got %b/%b exp 0/0",
                         bus.o_valid, bus.ow_ready);
    end
    repeat (2) @(negedge clk);
    rst_x = 1'b0;
    cq = '{10'h055};
    lq = '{1};
    model();
    drive(0, 200);
    checks++;
    if (tmo || od.size() != 1) begin
      errors++; $display("FAIL rmc_count got %0d exp 1 (tmo %0d)", od.size(), tmo);
    end else begin
      checks++;
      if (od[0] !== 8'h55 || ol[0] !== 1'b1) begin
        errors++; $display("FAIL rmc_data got %h/%b exp 55/1", od[0], ol[0]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int s = 0; s < 25; s++) begin
      cq.delete();
      lq.delete();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) begin
        logic [5:0] o;
        if ($urandom_range(0, 1) == 0) begin
          cq.push_back({1'b0, 9'($urandom)});
        end else begin
          o = ($urandom_range(0, 2) != 0) ? 6'($urandom_range(48, 63))
                                           : 6'($urandom);
          cq.push_back({1'b1, o, 3'($urandom)});
        end
        lq.push_back(i == n - 1);
      end
      model();
      drive(2, 3000);
      checks++;
      if (tmo || od.size() != ed.size()) begin
        errors++; $display("FAIL rnd%0d_count got %0d exp %0d (tmo %0d)",
                           s, od.size(), ed.size(), tmo);
      end else begin
        foreach (ed[i]) begin
          checks++;
          if (od[i] !== ed[i] || ol[i] !== el[i]) begin
            errors++; $display("FAIL rnd%0d_sym[%0d] got %h/%b exp %h/%b",
                               s, i, od[i], ol[i], ed[i], el[i]);
          end
        end
      end
      checks++;
      if (stall_bad != 0) begin
        errors++; $display("FAIL rnd%0d_stall_hold got %0d exp 0", s, stall_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_match_repeat();
    test_overlap(0);
    test_overlap(1);
    test_stream_restart();
    test_reset_mid_copy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
